// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : GF(2^8) helpers and MixColumns coefficients shared by the   |
// |           AES encrypt/decrypt datapaths and the key schedule.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  // Indexed by (byte position - output row) mod 4.
  localparam logic [7:0] INV_MC_COEF [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

  function automatic logic [7:0] gf_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_inv_mul_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf_inv_mul_8 : one byte times the InvMixColumns constants 9/B/D/E.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module gf_inv_mul_8
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] mul9,
  output logic [7:0] mulB,
  output logic [7:0] mulD,
  output logic [7:0] mulE
);

  logic [7:0] w_x2;
  logic [7:0] w_x4;
  logic [7:0] w_x8;

  assign w_x2 = gf_xtime(din);
  assign w_x4 = gf_xtime(w_x2);
  assign w_x8 = gf_xtime(w_x4);

  assign mul9 = w_x8 ^ din;
  assign mulB = w_x8 ^ w_x2 ^ din;
  assign mulD = w_x8 ^ w_x4 ^ din;
  assign mulE = w_x8 ^ w_x4 ^ w_x2;

endmodule
`default_nettype wire

// File: rtl/inv_mixcolumn_stream_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_mixcolumn_stream_8 : byte-serial AES InvMixColumns with a         |
// |                          double-buffered column output stage.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module inv_mixcolumn_stream_8
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam int            OCW       = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(NCOL - 1);

  logic [1:0]     icnt_q;
  logic [1:0]     ocnt_q;
  logic [OCW-1:0] ocol_q;
  logic           obuf_full_q;
  logic [7:0]     acc_q  [4];
  logic [7:0]     acc_d  [4];
  logic [7:0]     obuf_q [4];

  logic [7:0] w_mul9, w_mulB, w_mulD, w_mulE;
  logic [7:0] w_prod [4];
  logic       w_clr, w_in_fire, w_out_fire, w_pop_last, w_load;

  gf_inv_mul_8 u_mul (
    .din  (in_data),
    .mul9 (w_mul9),
    .mulB (w_mulB),
    .mulD (w_mulD),
    .mulE (w_mulE)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      case (INV_MC_COEF[k])
        8'h09:   w_prod[k] = w_mul9;
        8'h0B:   w_prod[k] = w_mulB;
        8'h0D:   w_prod[k] = w_mulD;
        default: w_prod[k] = w_mulE;
      endcase
    end
  end

  // Byte 0 of a column loads instead of XORing, so the accumulators self-clear.
  for (genvar i = 0; i < 4; i++) begin : g_acc
    logic [1:0] w_k;
    assign w_k      = icnt_q - 2'(i);
    assign acc_d[i] = (icnt_q == 2'd0) ? w_prod[w_k] : (acc_q[i] ^ w_prod[w_k]);
  end

  assign w_clr      = rst | flush;
  assign w_out_fire = obuf_full_q & out_ready;
  assign w_pop_last = w_out_fire & (ocnt_q == 2'd3);
  assign in_ready   = (icnt_q != 2'd3) | ~obuf_full_q | w_pop_last;
  assign w_in_fire  = in_valid & in_ready;
  assign w_load     = w_in_fire & (icnt_q == 2'd3);

  assign out_valid = obuf_full_q;
  assign out_data  = obuf_q[ocnt_q];
  assign out_last  = obuf_full_q & (ocol_q == OCOL_LAST) & (ocnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      icnt_q      <= 2'd0;
      ocnt_q      <= 2'd0;
      ocol_q      <= '0;
      obuf_full_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= 8'h00;
        obuf_q[i] <= 8'h00;
      end
    end else begin
      if (w_in_fire) begin
        icnt_q <= icnt_q + 2'd1;
        for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
      end
      // A column load beats a same-cycle final pop.
      if (w_load) begin
        for (int i = 0; i < 4; i++) obuf_q[i] <= acc_d[i];
        obuf_full_q <= 1'b1;
        ocnt_q      <= 2'd0;
      end else if (w_out_fire) begin
        ocnt_q <= ocnt_q + 2'd1;
        if (ocnt_q == 2'd3) obuf_full_q <= 1'b0;
      end
      if (w_pop_last) begin
        ocol_q <= (ocol_q == OCOL_LAST) ? '0 : ocol_q + OCW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcolumn_stream_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inv_mixcolumn_stream_8 : directed and throttled-random checks.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_inv_mixcolumn_stream_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;

  int         n_cmp = 0;
  int         n_err = 0;
  int         stalls = 0;
  int         obyte = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  inv_mixcolumn_stream_8 #(.NCOL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] col, input logic [31:0] cf);
    logic [7:0]  a [4];
    logic [7:0]  c [4];
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a[i] = col[31-8*i -: 8];
      c[i] = cf[31-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = gmul(c[0], a[i]) ^ gmul(c[1], a[(i+1)%4]) ^
                       gmul(c[2], a[(i+2)%4]) ^ gmul(c[3], a[(i+3)%4]);
    end
    return r;
  endfunction

  // Output monitor: every transfer is scored against the expected queue.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      obyte = 0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        chk("out_last", 32'(out_last), 32'((obyte % 16) == 15));
      end
      obyte++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called and returning at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready) begin
      stalls++;
      t++;
      if (t > 300) begin
        chk("in_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_col(input logic [31:0] col, input int gmax);
    for (int j = 0; j < 4; j++)
      send_byte(col[31-8*j -: 8], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
  endtask

  task automatic expect_col(input logic [31:0] col);
    for (int j = 0; j < 4; j++) exp_q.push_back(col[31-8*j -: 8]);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single column and first-byte latency
    out_ready = 1'b1;
    expect_col(32'hdb135345);
    send_byte(8'h8e, 0);
    send_byte(8'h4d, 0);
    send_byte(8'ha1, 0);
    @(negedge clk);
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'hbc, 0);
    @(negedge clk);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_first_byte", 32'(out_data), 32'hdb);
    wait_drain("t1_drain");

    // Back-to-back columns, no input stalls
    stalls = 0;
    expect_col(32'hf20a225c);
    expect_col(32'hd4d4d4d5);
    send_col(32'h9fdc589d, 0);
    send_col(32'hd5d5d7d6, 0);
    chk("t2_in_stalls", 32'(stalls), 32'd0);
    wait_drain("t2_drain");

    // One full NCOL block, out_last on byte 16 only
    do_reset();
    expect_col(32'h01010101);
    expect_col(32'hc6c6c6c6);
    expect_col(32'hdb135345);
    expect_col(32'hf20a225c);
    send_col(32'h01010101, 0);
    send_col(32'hc6c6c6c6, 0);
    send_col(32'h8e4da1bc, 0);
    send_col(32'h9fdc589d, 0);
    wait_drain("t3_drain");

    // Downstream backpressure
    do_reset();
    out_ready = 1'b0;
    expect_col(32'hdb135345);
    expect_col(32'hd4d4d4d5);
    fork
      begin
        send_col(32'h8e4da1bc, 0);
        send_col(32'hd5d5d7d6, 0);
      end
      begin
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("t4_in_ready_low", 32'(in_ready), 32'd0);
        chk("t4_valid_held", 32'(out_valid), 32'd1);
        chk("t4_data_held_a", 32'(out_data), 32'hdb);
        repeat (3) @(negedge clk);
        chk("t4_data_held_b", 32'(out_data), 32'hdb);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // Flush mid-column
    send_byte(8'h8e, 0);
    send_byte(8'h4d, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    expect_col(32'hf20a225c);
    send_col(32'h9fdc589d, 0);
    wait_drain("t5_drain");

    // Reset mid-drain: remaining bytes must vanish
    out_ready = 1'b0;
    expect_col(32'hdb135345);
    send_col(32'h8e4da1bc, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    expect_col(32'hd4d4d4d5);
    send_col(32'hd5d5d7d6, 0);
    wait_drain("t6_drain");

    // Throttled random: odd columns go through a forward mix first
    do_reset();
    rnd_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      a = $urandom;
      if (c % 2 == 1) begin
        expect_col(a);
        send_col(mix(a, 32'h02030101), 2);
      end else begin
        expect_col(mix(a, 32'h0e0b0d09));
        send_col(a, 2);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain("t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
